// File: rtl/reg_out_pipe.sv
// reg_out_pipe: x2->x3 output-port pipeline register; a stalled x2 instruction becomes an x3 bubble
module reg_out_pipe #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stalled,
    input  logic              dataoutvx2,
    input  logic [DATA_W-1:0] dataoutx2,
    output logic              stalledx3,
    output logic              dataoutvx3,
    output logic [DATA_W-1:0] dataoutx3
);
    logic load;
    assign load = dataoutvx2 && !stalled;
    always_ff @(posedge clock) begin
        if (reset) begin
            stalledx3  <= 1'b0;
            dataoutvx3 <= 1'b0;
            dataoutx3  <= '0;
        end else begin
            stalledx3  <= stalled;
            dataoutvx3 <= load;
            dataoutx3  <= load ? dataoutx2 : dataoutx3;
        end
    end
endmodule

// File: tb/tb_reg_out_pipe.sv
// tb_reg_out_pipe: directed and random checks of reg_out_pipe against a transfer-level model
module tb_reg_out_pipe;
    logic        clock = 1'b0;
    logic        reset, stalled, dataoutvx2;
    logic [15:0] dataoutx2;
    logic        stalledx3, dataoutvx3;
    logic [15:0] dataoutx3;
    logic        exp_s, exp_v;
    logic [15:0] exp_d;
    int          n_cmp = 0;
    int          n_bad = 0;

    reg_out_pipe #(.DATA_W(16)) dut (
        .clock(clock), .reset(reset), .stalled(stalled), .dataoutvx2(dataoutvx2),
        .dataoutx2(dataoutx2), .stalledx3(stalledx3), .dataoutvx3(dataoutvx3),
        .dataoutx3(dataoutx3)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs, advance past the edge and update the model
    task automatic cycle(input logic r, input logic s, input logic v, input logic [15:0] d);
        reset = r; stalled = s; dataoutvx2 = v; dataoutx2 = d;
        @(posedge clock);
        #1;
        if (r) begin
            exp_s = 0; exp_v = 0; exp_d = 0;
        end else begin
            exp_s = s;
            exp_v = v && !s;
            if (v && !s) exp_d = d;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1'($urandom), 1'($urandom), 16'($urandom));
            n_cmp++;
            if ({stalledx3, dataoutvx3, dataoutx3} !== 18'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got s=%b v=%b d=%h want all 0", i, stalledx3, dataoutvx3, dataoutx3);
            end
        end
    endtask

    task automatic test_load();
        cycle(0, 0, 1, 16'hA5A5);
        n_cmp++;
        if ({stalledx3, dataoutvx3, dataoutx3} !== {1'b0, 1'b1, 16'hA5A5}) begin
            n_bad++;
            $display("FAIL load: got s=%b v=%b d=%h want s=0 v=1 d=a5a5", stalledx3, dataoutvx3, dataoutx3);
        end
    endtask

    task automatic test_stall();
        cycle(0, 0, 1, 16'h1234);
        cycle(0, 1, 1, 16'hFFFF);
        n_cmp++;
        if ({stalledx3, dataoutvx3, dataoutx3} !== {1'b1, 1'b0, 16'h1234}) begin
            n_bad++;
            $display("FAIL stall: got s=%b v=%b d=%h want s=1 v=0 d=1234", stalledx3, dataoutvx3, dataoutx3);
        end
        cycle(0, 1, 1, 16'hxxxx);
        n_cmp++;
        if ({dataoutvx3, dataoutx3} !== {1'b0, 16'h1234}) begin
            n_bad++;
            $display("FAIL stall_x: got v=%b d=%h want v=0 d=1234", dataoutvx3, dataoutx3);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 1, 16'(i));
            n_cmp++;
            if ({dataoutvx3, dataoutx3} !== {1'b1, 16'(i)}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", i, dataoutvx3, dataoutx3, 16'(i));
            end
        end
        cycle(0, 0, 0, 16'hxxxx);
        n_cmp++;
        if ({dataoutvx3, dataoutx3} !== {1'b0, 16'h0003}) begin
            n_bad++;
            $display("FAIL b2b_idle: got v=%b d=%h want v=0 d=0003", dataoutvx3, dataoutx3);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 1, 16'h0A0A);
        cycle(0, 0, 1, 16'h0B0B);
        cycle(1, 0, 1, 16'h0C0C);
        n_cmp++;
        if ({stalledx3, dataoutvx3, dataoutx3} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got s=%b v=%b d=%h want all 0", stalledx3, dataoutvx3, dataoutx3);
        end
        cycle(0, 0, 1, 16'h00C3);
        n_cmp++;
        if ({dataoutvx3, dataoutx3} !== {1'b1, 16'h00C3}) begin
            n_bad++;
            $display("FAIL reset_release: got v=%b d=%h want v=1 d=00c3", dataoutvx3, dataoutx3);
        end
    endtask

    task automatic test_stall_toggle();
        logic [3:0] pat = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle(0, pat[i], 1, 16'($urandom));
            n_cmp++;
            if (stalledx3 !== pat[i]) begin
                n_bad++;
                $display("FAIL stall_toggle[%0d]: got s=%b want %b", i, stalledx3, pat[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 16'($urandom));
            n_cmp++;
            if ({stalledx3, dataoutvx3, dataoutx3} !== {exp_s, exp_v, exp_d}) begin
                n_bad++;
                $display("FAIL random[%0d]: got s=%b v=%b d=%h want s=%b v=%b d=%h",
                         i, stalledx3, dataoutvx3, dataoutx3, exp_s, exp_v, exp_d);
            end
        end
    endtask

    initial begin
        exp_s = 0; exp_v = 0; exp_d = 0;
        reset = 1; stalled = 0; dataoutvx2 = 0; dataoutx2 = '0;
        test_reset();
        test_load();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_stall_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
